// File: rtl/udp02467_sweep_checker.sv
// rtl/udp02467_sweep_checker.sv - stimulus/response sweep engine for the UDP-02467 circuit
module udp02467_sweep_checker #(
   parameter int SETTLE = 2
) (
   input  logic       Clock,
   input  logic       reset_b,
   input  logic       start,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   input  logic       E,
   input  logic       F,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       first_fail_valid,
   output logic [3:0] first_fail_idx,
   output logic       rsp_valid,
   output logic [3:0] rsp_idx,
   output logic       rsp_E,
   output logic       rsp_F,
   output logic       rsp_err
);

   // A settle of 0 is treated as 1, so the reload value bottoms out at 0.
   localparam logic [3:0] CNT_RELOAD = (SETTLE <= 1) ? 4'd0 : 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] idx;
   logic [3:0] idx_nxt;
   logic [3:0] cnt;
   logic       start_sweep;
   logic       sample;
   logic       last_vec;
   logic       e_exp;
   logic       f_exp;
   logic       mismatch;

   // start is honoured only outside RUN; sampling happens when the settle counter expires
   assign start_sweep = start && (state != ST_RUN);
   assign sample      = (state == ST_RUN) && (cnt == 4'd0);
   assign last_vec    = sample && (idx == 4'd15);
   assign idx_nxt     = idx + 4'd1;

   // Golden function evaluated on the vector currently driven: D = ~idx[3], {A,B,C} = idx[2:0]
   assign e_exp    = ~idx[0] | (idx[2] & idx[1]);
   assign f_exp    = e_exp & ~idx[3];
   assign mismatch = (E != e_exp) || (F != f_exp);

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == 5'd0);

   // State register
   always_ff @(posedge Clock or negedge reset_b) begin
      if (!reset_b) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE/DONE wait for start, RUN ends after the sample of vector 15
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (last_vec) state_nxt = ST_DONE;
         ST_DONE: if (start) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Vector sequencing: index, settle counter and registered stimulus move together
   always_ff @(posedge Clock or negedge reset_b) begin
      if (!reset_b) begin
         idx <= 4'd0;
         cnt <= 4'd0;
         A   <= 1'b0;
         B   <= 1'b0;
         C   <= 1'b0;
         D   <= 1'b0;
      end else if (start_sweep) begin
         idx <= 4'd0;
         cnt <= CNT_RELOAD;
         A   <= 1'b0;
         B   <= 1'b0;
         C   <= 1'b0;
         D   <= 1'b1;
      end else if (state == ST_RUN) begin
         if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else if (!last_vec) begin
            idx <= idx_nxt;
            cnt <= CNT_RELOAD;
            A   <= idx_nxt[2];
            B   <= idx_nxt[1];
            C   <= idx_nxt[0];
            D   <= ~idx_nxt[3];
         end
      end
   end

   // Result accumulation: cleared on every sweep start, held through DONE
   always_ff @(posedge Clock or negedge reset_b) begin
      if (!reset_b) begin
         err_count        <= 5'd0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= 4'd0;
      end else if (start_sweep) begin
         err_count        <= 5'd0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= 4'd0;
      end else if (sample && mismatch) begin
         err_count <= err_count + 5'd1;
         if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx;
         end
      end
   end

   // Per-vector response record, valid for one cycle after each sample edge
   always_ff @(posedge Clock or negedge reset_b) begin
      if (!reset_b) begin
         rsp_valid <= 1'b0;
         rsp_idx   <= 4'd0;
         rsp_E     <= 1'b0;
         rsp_F     <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= sample;
         if (sample) begin
            rsp_idx <= idx;
            rsp_E   <= E;
            rsp_F   <= F;
            rsp_err <= mismatch;
         end
      end
   end

endmodule
